nv_nvdla_cacc_slcg_en_ctrl: RTL
===============================

Name: nv_nvdla_cacc_slcg_en_ctrl

Overview:
- Upstream enable generator for the CACC second-level clock-gating cell.
- Watches CACC activity and request traffic, and drives the clock-enable that feeds the gating cell's slcg_en_src_0 input.
- Applies idle hysteresis before gating the clock, and a fixed wake latency before it accepts new work.
- Honours the override and test-disable inputs, and keeps a saturating gated-cycle performance counter.

Parameters:
- IDLE_HOLD, 16: consecutive idle cycles required before the clock is gated (valid range 1..255).
- WAKE_LAT, 2: cycles from clock re-enable to request acceptance (valid range 1..15).
- PERF_W, 32: width of the gated-cycle counter.

Ports:
- nvdla_core_clk  in  1  free-running core clock (ungated side).
- nvdla_core_rst  in  1  reset; one clock; asynchronous assert, active-high.
- reg2dp_slcg_op_en  in  1  software enable for clock gating; 0 keeps the clock always on.
- dla_clk_ovr_on_sync  in  1  DLA clock override (synchronised); forces the clock on.
- global_clk_ovr_on_sync  in  1  global clock override (synchronised); forces the clock on.
- tmc2slcg_disable_clock_gating  in  1  test-mode disable; forces the clock on.
- cacc_busy  in  1  CACC datapath has in-flight work.
- req_vld  in  1  upstream request valid (new accumulation traffic).
- req_rdy  out  1  request accepted this cycle when req_vld & req_rdy.
- slcg_clk_en  out  1  clock enable to the gating cell (1 = clock runs).
- gated_cnt  out  PERF_W  number of cycles slcg_clk_en was 0; saturates at all-ones.
- gated_cnt_clr  in  1  synchronous clear of gated_cnt.

Behaviour:
- force_on = ~reg2dp_slcg_op_en | dla_clk_ovr_on_sync | global_clk_ovr_on_sync | tmc2slcg_disable_clock_gating.
- idle = ~cacc_busy & ~req_vld.
- FSM states are RUN, HOLD, GATED and WAKE; all outputs are registered.
- Reset values: state=RUN, slcg_clk_en=1, req_rdy=1, idle_cnt=0, wake_cnt=0, gated_cnt=0.
- RUN:
  - slcg_clk_en=1, req_rdy=1.
  - If idle & ~force_on, go to HOLD with idle_cnt=1.
- HOLD:
  - slcg_clk_en=1, req_rdy=1.
  - If ~idle or force_on, go to RUN and clear idle_cnt.
  - Otherwise, if idle_cnt==IDLE_HOLD, go to GATED.
  - Otherwise, idle_cnt+1.
  - With IDLE_HOLD=1, GATED is entered the cycle after HOLD is entered.
- GATED:
  - slcg_clk_en=0, req_rdy=0.
  - If req_vld | cacc_busy | force_on, go to WAKE with wake_cnt=0, and slcg_clk_en=1 from the next cycle.
- WAKE:
  - slcg_clk_en=1, req_rdy=0.
  - wake_cnt increments each cycle; when wake_cnt==WAKE_LAT-1, go to RUN.
  - req_rdy therefore rises exactly WAKE_LAT cycles after slcg_clk_en rises.
  - force_on and idle do not abort WAKE.
- req_vld must be held until accepted. A request arriving in GATED sees req_rdy=1 after 1+WAKE_LAT cycles.
- Priority when force_on and idle occur in the same cycle: force_on wins; the FSM never leaves RUN or HOLD toward GATED while force_on=1.
- force_on rising during GATED: the registered slcg_clk_en rises on the next cycle.
- gated_cnt:
  - Increments on every cycle that registered slcg_clk_en==0.
  - Holds at 2^PERF_W-1.
  - gated_cnt_clr takes priority over increment; clear and increment in the same cycle yields 0.
- Reset asserted mid-operation (any state): immediate return to reset values, with the clock enabled.
- This block is clocked by nvdla_core_clk (ungated) and never by the gated clock.

Test Plan:
- Reset release with all inputs 0 and reg2dp_slcg_op_en=1, IDLE_HOLD=16 -> slcg_clk_en falls exactly 17 cycles after idle begins; gated_cnt starts counting on the following cycle.
- Idle for 10 cycles, then cacc_busy=1 for 1 cycle, then idle -> no gating until 17 fresh idle cycles have elapsed; idle_cnt restarts.
- In GATED, pulse req_vld=1 (held) with WAKE_LAT=2 -> slcg_clk_en=1 one cycle later, req_rdy=1 two cycles after that, handshake completes, and gated_cnt stops incrementing.
- tmc2slcg_disable_clock_gating=1 (also repeated with each override input and with reg2dp_slcg_op_en=0) while GATED -> slcg_clk_en=1 next cycle; after 1000 idle cycles there is no regating and gated_cnt is unchanged.
- gated_cnt preloaded near saturation (PERF_W=4 build), 20 gated cycles -> holds at 15; gated_cnt_clr on an increment cycle -> reads 0.
- Assert nvdla_core_rst during WAKE and during GATED -> slcg_clk_en=1, req_rdy=1, gated_cnt=0 in the same cycle (async); normal hysteresis after release.

Source files
------------

// File: rtl/nv_nvdla_cacc_slcg_en_ctrl.sv
// CACC second-level clock-gating enable generator: idle hysteresis before gating,
// fixed wake latency before accepting requests, and a saturating gated-cycle counter.
module nv_nvdla_cacc_slcg_en_ctrl #(
    parameter int unsigned IDLE_HOLD = 16,
    parameter int unsigned WAKE_LAT  = 2,
    parameter int unsigned PERF_W    = 32
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              reg2dp_slcg_op_en,
    input  logic              dla_clk_ovr_on_sync,
    input  logic              global_clk_ovr_on_sync,
    input  logic              tmc2slcg_disable_clock_gating,
    input  logic              cacc_busy,
    input  logic              req_vld,
    output logic              req_rdy,
    output logic              slcg_clk_en,
    output logic [PERF_W-1:0] gated_cnt,
    input  logic              gated_cnt_clr
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_GATED = 2'd2;
    localparam logic [1:0] ST_WAKE  = 2'd3;

    localparam logic [7:0] IDLE_HOLD_C = 8'(IDLE_HOLD);
    localparam logic [3:0] WAKE_LAST_C = 4'(WAKE_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        idle_cnt_q, idle_cnt_d;
    logic [3:0]        wake_cnt_q, wake_cnt_d;
    logic              slcg_clk_en_q, slcg_clk_en_d;
    logic              req_rdy_q, req_rdy_d;
    logic [PERF_W-1:0] gated_cnt_q, gated_cnt_d;
    logic              force_on;
    logic              idle;

    assign force_on = ~reg2dp_slcg_op_en | dla_clk_ovr_on_sync |
                      global_clk_ovr_on_sync | tmc2slcg_disable_clock_gating;
    assign idle     = ~cacc_busy & ~req_vld;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (idle && !force_on) begin
                    state_d    = ST_HOLD;
                    idle_cnt_d = 8'd1;
                end
            end
            ST_HOLD: begin
                if (!idle || force_on) begin
                    state_d    = ST_RUN;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_HOLD_C) begin
                    state_d    = ST_GATED;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            ST_GATED: begin
                if (req_vld || cacc_busy || force_on) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                // Wake always runs to completion; force_on and idle are ignored here.
                if (wake_cnt_q == WAKE_LAST_C) begin
                    state_d    = ST_RUN;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                idle_cnt_d = '0;
                wake_cnt_d = '0;
            end
        endcase
    end

    // Outputs are registered copies decoded from the next state.
    always_comb begin
        slcg_clk_en_d = (state_d != ST_GATED);
        req_rdy_d     = (state_d == ST_RUN) || (state_d == ST_HOLD);
    end

    always_comb begin
        gated_cnt_d = gated_cnt_q;
        if (gated_cnt_clr) begin
            gated_cnt_d = '0;
        end else if (!slcg_clk_en_q && (gated_cnt_q != '1)) begin
            gated_cnt_d = gated_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q       <= ST_RUN;
            idle_cnt_q    <= '0;
            wake_cnt_q    <= '0;
            slcg_clk_en_q <= 1'b1;
            req_rdy_q     <= 1'b1;
            gated_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            wake_cnt_q    <= wake_cnt_d;
            slcg_clk_en_q <= slcg_clk_en_d;
            req_rdy_q     <= req_rdy_d;
            gated_cnt_q   <= gated_cnt_d;
        end
    end

    assign slcg_clk_en = slcg_clk_en_q;
    assign req_rdy     = req_rdy_q;
    assign gated_cnt   = gated_cnt_q;

endmodule
